// File: rtl/vga_pixmem_arbiter.sv
// rtl/vga_pixmem_arbiter.sv - display-priority arbiter sharing one single-port pixel RAM with a host port
module vga_pixmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int RD_LAT       = 2,
  parameter int WAIT_W       = 12,
  parameter int STARVE_LIMIT = 2048
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DISP_REQ,
  input  logic [AW-1:0] DISP_ADDR,
  output logic          DISP_VALID,
  output logic [DW-1:0] DISP_DATA,
  input  logic          HOST_VALID,
  output logic          HOST_READY,
  input  logic          HOST_WE,
  input  logic [AW-1:0] HOST_ADDR,
  input  logic [DW-1:0] HOST_WDATA,
  output logic          HOST_RVALID,
  output logic [DW-1:0] HOST_RDATA,
  output logic          HOST_STARVE,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [DW-1:0]          mem_wdata_q, mem_wdata_d;
  // Each stage carries {display read, host read}; the last stage lines up with MEM_RDATA.
  logic [RD_LAT:0][1:0]   tag_q, tag_d;
  logic                   disp_valid_q, disp_valid_d;
  logic [DW-1:0]          disp_data_q, disp_data_d;
  logic                   host_rvalid_q, host_rvalid_d;
  logic [DW-1:0]          host_rdata_q, host_rdata_d;
  logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                   starve_q, starve_d;
  logic                   host_accept;
  logic [1:0]             exit_tag;

  assign HOST_READY  = !DISP_REQ && (state_q == IDLE);
  assign host_accept = HOST_VALID && HOST_READY;
  assign exit_tag    = tag_q[RD_LAT];

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (DISP_REQ) begin
      mem_addr_d = DISP_ADDR;
    end else if (host_accept) begin
      mem_addr_d = HOST_ADDR;
      mem_we_d   = HOST_WE;
      if (HOST_WE) begin
        mem_wdata_d = HOST_WDATA;
      end
    end

    tag_d[0] = {DISP_REQ, host_accept && !HOST_WE};
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    disp_valid_d  = exit_tag[1];
    disp_data_d   = exit_tag[1] ? MEM_RDATA : disp_data_q;
    host_rvalid_d = exit_tag[0];
    host_rdata_d  = exit_tag[0] ? MEM_RDATA : host_rdata_q;

    state_d = state_q;
    case (state_q)
      IDLE:    if (host_accept && !HOST_WE) state_d = RD_WAIT;
      RD_WAIT: if (exit_tag[0])             state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counts only cycles where the host is actively held off; accept or withdrawal clears it.
    wait_cnt_d = '0;
    if (HOST_VALID && !HOST_READY) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    starve_d = {{(32-WAIT_W){1'b0}}, wait_cnt_d} >= 32'(STARVE_LIMIT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      tag_q         <= '0;
      disp_valid_q  <= 1'b0;
      disp_data_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      wait_cnt_q    <= '0;
      starve_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      tag_q         <= tag_d;
      disp_valid_q  <= disp_valid_d;
      disp_data_q   <= disp_data_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      wait_cnt_q    <= wait_cnt_d;
      starve_q      <= starve_d;
    end
  end

  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign DISP_VALID  = disp_valid_q;
  assign DISP_DATA   = disp_data_q;
  assign HOST_RVALID = host_rvalid_q;
  assign HOST_RDATA  = host_rdata_q;
  assign HOST_STARVE = starve_q;

endmodule
